// File: rtl/btn_conditioner_multi_if.sv
// Button front-end bundle: pad levels and pulse enable in, debounced level and
// single-cycle event strobes out.
interface btn_conditioner_multi_if #(
   parameter int NUM_BTN = 5
);
   logic               en;
   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] press_p;
   logic [NUM_BTN-1:0] release_p;
   logic [NUM_BTN-1:0] repeat_p;
   logic [NUM_BTN-1:0] action_p;

   modport master (
      output en, btn_raw,
      input  btn_level, press_p, release_p, repeat_p, action_p
   );

   modport slave (
      input  en, btn_raw,
      output btn_level, press_p, release_p, repeat_p, action_p
   );
endinterface

// File: rtl/btn_conditioner_multi.sv
// N-channel push-button conditioner: synchroniser, per-channel debounce and
// press/release/auto-repeat pulse generation for the stopwatch control FSM.
module btn_conditioner_multi #(
   parameter int                 NUM_BTN       = 5,
   parameter int                 SYNC_STAGES   = 2,
   parameter int                 STABLE_CYCLES = 7_000_000,
   parameter int                 HOLD_CYCLES   = 50_000_000,
   parameter int                 REPEAT_CYCLES = 20_000_000,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK   = 5'b11000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   btn_conditioner_multi_if.slave btn_if
);
   localparam int DCW  = $clog2(STABLE_CYCLES + 1);
   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HCW  = $clog2(HMAX + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   if (STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 || SYNC_STAGES < 2) begin : g_param_check
      $error("btn_conditioner_multi: illegal parameter combination");
   end

   logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= btn_if.btn_raw;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      logic           s;
      logic [DCW-1:0] dcnt_q, dcnt_d;
      logic           level_q, level_d;
      logic [1:0]     state_q, state_d;
      logic [HCW-1:0] hcnt_q, hcnt_d;
      logic           repeat_d;
      logic           press_q, release_q, repeat_q;

      assign s = sync_q[SYNC_STAGES-1][gi];

      // Any cycle where the synced input agrees with the level restarts the window.
      always_comb begin
         dcnt_d  = '0;
         level_d = level_q;
         if (s != level_q) begin
            if (dcnt_q == DCW'(STABLE_CYCLES - 1)) level_d = ~level_q;
            else                                   dcnt_d  = dcnt_q + 1'b1;
         end
      end

      always_comb begin
         state_d  = state_q;
         hcnt_d   = hcnt_q;
         repeat_d = 1'b0;
         if (level_q && !level_d) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (!level_q && level_d) begin
                     state_d = ST_HOLD;
                     hcnt_d  = '0;
                  end
               end
               ST_HOLD: begin
                  if (hcnt_q == HCW'(HOLD_CYCLES - 1)) begin
                     // Unmasked channels park here with the counter saturated.
                     if (REPEAT_MASK[gi]) begin
                        repeat_d = 1'b1;
                        state_d  = ST_REPEAT;
                        hcnt_d   = '0;
                     end
                  end else begin
                     hcnt_d = hcnt_q + 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (hcnt_q == HCW'(REPEAT_CYCLES - 1)) begin
                     repeat_d = 1'b1;
                     hcnt_d   = '0;
                  end else begin
                     hcnt_d = hcnt_q + 1'b1;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  hcnt_d  = '0;
               end
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            state_q   <= ST_IDLE;
            hcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
         end else begin
            dcnt_q    <= dcnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            press_q   <= ~level_q & level_d;
            release_q <= level_q & ~level_d;
            repeat_q  <= repeat_d;
         end
      end

      // Gating at the output means a pulse suppressed by en is simply lost.
      assign btn_if.btn_level[gi] = level_q;
      assign btn_if.press_p[gi]   = press_q & btn_if.en;
      assign btn_if.release_p[gi] = release_q & btn_if.en;
      assign btn_if.repeat_p[gi]  = repeat_q & btn_if.en;
      assign btn_if.action_p[gi]  = (press_q | repeat_q) & btn_if.en;
   end
endmodule

// File: tb/tb_btn_conditioner_multi.sv
// Directed bench for btn_conditioner_multi with short debounce/hold/repeat times.
module tb_btn_conditioner_multi;
   localparam int N = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   btn_conditioner_multi_if #(.NUM_BTN(N)) bif ();

   btn_conditioner_multi #(
      .NUM_BTN(N), .SYNC_STAGES(2), .STABLE_CYCLES(8), .HOLD_CYCLES(20),
      .REPEAT_CYCLES(5), .REPEAT_MASK(5'b11000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_if(bif)
   );

   int n_tests = 0, n_fail = 0, t = 0;
   int n_press [N], n_rel [N], n_rep [N], n_act [N];
   int press_t [N], rel_t [N], first_rep [N], last_rep [N];
   int tp, tr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < N; i++) begin
         n_press[i] = 0; n_rel[i] = 0; n_rep[i] = 0; n_act[i] = 0;
         press_t[i] = -1; rel_t[i] = -1; first_rep[i] = -1; last_rep[i] = -1;
      end
   endtask

   // One clock cycle: sample outputs at the falling edge and log events.
   task automatic tick();
      @(negedge clk);
      t++;
      for (int i = 0; i < N; i++) begin
         if (bif.press_p[i])   begin n_press[i]++; press_t[i] = t; end
         if (bif.release_p[i]) begin n_rel[i]++;   rel_t[i]   = t; end
         if (bif.repeat_p[i]) begin
            n_rep[i]++;
            if (first_rep[i] < 0) first_rep[i] = t;
            last_rep[i] = t;
         end
         if (bif.action_p[i]) n_act[i]++;
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   function automatic int total_events();
      int s = 0;
      for (int i = 0; i < N; i++) s += n_press[i] + n_rel[i] + n_rep[i] + n_act[i];
      return s;
   endfunction

   initial begin
      rst_n = 1'b0;
      bif.en = 1'b1;
      bif.btn_raw = 5'h1F;
      clr();

      // 1: reset with all buttons held, then release reset
      ticks(3);
      chk("rst_level", 32'(bif.btn_level), 32'h0);
      chk("rst_pulses", 32'({bif.press_p, bif.release_p, bif.repeat_p, bif.action_p}), 32'h0);
      rst_n = 1'b1;
      clr();
      ticks(9);
      chk("t1_level_pre", 32'(bif.btn_level), 32'h0);
      tick();
      chk("t1_level", 32'(bif.btn_level), 32'h1F);
      chk("t1_press", 32'(bif.press_p), 32'h1F);
      chk("t1_action", 32'(bif.action_p), 32'h1F);
      tick();
      chk("t1_press_1cyc", 32'(bif.press_p), 32'h0);
      bif.btn_raw = 5'h00;
      ticks(9);
      chk("t1_level_hold", 32'(bif.btn_level), 32'h1F);
      tick();
      chk("t1_release", 32'(bif.release_p), 32'h1F);
      chk("t1_level_low", 32'(bif.btn_level), 32'h0);
      chk("t1_no_repeat", 32'(n_rep[3] + n_rep[4]), 32'd0);

      // 2: bouncing channel 0 settles high
      clr();
      ticks(5);
      for (int k = 0; k < 10; k++) begin
         bif.btn_raw[0] = ~bif.btn_raw[0];
         ticks(3);
      end
      bif.btn_raw[0] = 1'b1;
      ticks(9);
      chk("t2_level_pre", 32'(bif.btn_level[0]), 32'd0);
      tick();
      chk("t2_level", 32'(bif.btn_level[0]), 32'd1);
      chk("t2_press_cnt", 32'(n_press[0]), 32'd1);
      chk("t2_rel_cnt", 32'(n_rel[0]), 32'd0);
      bif.btn_raw[0] = 1'b0;
      ticks(15);

      // 3: glitch one cycle shorter than the debounce window
      clr();
      bif.btn_raw[2] = 1'b1;
      ticks(7);
      bif.btn_raw[2] = 1'b0;
      ticks(20);
      chk("t3_events", 32'(total_events()), 32'd0);
      chk("t3_level", 32'(bif.btn_level), 32'h0);

      // 4: auto-repeat on channel 3, release coinciding with a repeat slot
      clr();
      bif.btn_raw[3] = 1'b1;
      ticks(10);
      chk("t4_press", 32'(bif.press_p), 32'h08);
      tp = t;
      ticks(60);
      chk("t4_rep_cnt", 32'(n_rep[3]), 32'd9);
      chk("t4_first_rep", 32'(first_rep[3] - tp), 32'd20);
      chk("t4_last_rep", 32'(last_rep[3] - tp), 32'd60);
      chk("t4_action_cnt", 32'(n_act[3]), 32'd10);
      bif.btn_raw[3] = 1'b0;
      ticks(10);
      chk("t4_release", 32'(bif.release_p), 32'h08);
      chk("t4_no_rep_on_release", 32'(bif.repeat_p), 32'h0);
      chk("t4_last_rep_before_fall", 32'(last_rep[3] - tp), 32'd65);
      ticks(30);
      chk("t4_rep_total", 32'(n_rep[3]), 32'd10);
      chk("t4_rel_cnt", 32'(n_rel[3]), 32'd1);

      // 5: unmasked channel 0 never repeats
      clr();
      bif.btn_raw[0] = 1'b1;
      ticks(70);
      chk("t5_press_cnt", 32'(n_press[0]), 32'd1);
      chk("t5_rep_cnt", 32'(n_rep[0]), 32'd0);
      chk("t5_action_cnt", 32'(n_act[0]), 32'd1);
      bif.btn_raw[0] = 1'b0;
      tr = t;
      ticks(12);
      chk("t5_rel_latency", 32'(rel_t[0] - tr), 32'd10);
      chk("t5_rel_cnt", 32'(n_rel[0]), 32'd1);

      // 6: enable dropped mid-hold on channel 4
      clr();
      bif.btn_raw[4] = 1'b1;
      ticks(10);
      chk("t6_press", 32'(bif.press_p), 32'h10);
      tp = t;
      ticks(10);
      bif.en = 1'b0;
      clr();
      ticks(22);
      chk("t6_muted", 32'(total_events()), 32'd0);
      chk("t6_level_kept", 32'(bif.btn_level), 32'h10);
      bif.en = 1'b1;
      clr();
      ticks(8);
      chk("t6_first_rep_phase", 32'(first_rep[4] - tp), 32'd35);
      chk("t6_rep_cnt", 32'(n_rep[4]), 32'd2);
      chk("t6_last_rep", 32'(last_rep[4] - tp), 32'd40);
      bif.btn_raw[4] = 1'b0;
      ticks(15);

      // 7: asynchronous reset during a channel-3 hold
      clr();
      bif.btn_raw[3] = 1'b1;
      ticks(10);
      ticks(12);
      chk("t7_level_before", 32'(bif.btn_level), 32'h08);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_async_level", 32'(bif.btn_level), 32'h0);
      chk("t7_async_pulses", 32'({bif.press_p, bif.release_p, bif.repeat_p, bif.action_p}), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clr();
      ticks(9);
      chk("t7_level_pre", 32'(bif.btn_level[3]), 32'd0);
      tick();
      chk("t7_fresh_press", 32'(bif.press_p), 32'h08);
      tp = t;
      ticks(20);
      chk("t7_first_rep", 32'(first_rep[3] - tp), 32'd20);
      chk("t7_rep_cnt", 32'(n_rep[3]), 32'd1);
      chk("t7_rel_cnt", 32'(n_rel[3]), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
